count_display_driver: RTL and testbench
=======================================

// Module: count_display_driver
// PURPOSE
//  Downstream consumer of the 5-bit up/down sync counter (range 0..30, wraps 30->0 up, 0->30 down).
//  Samples the counter value, converts it to two decimal digits and drives a time-multiplexed
//  2-digit common-anode 7-segment display. Detects counter wrap events, counts them, and blanks
//  the display briefly on each wrap.
// PARAMETERS
//  SCAN_DIV   1000  clocks per digit slot; >=2
//  FLASH_CYC  4096  clocks the display stays blanked after a wrap; >=1
// PORTS
//  clk         input   1  system clock, rising edge
//  rst         input   1  asynchronous, active-low reset
//  value       input   5  counter value from upstream counter (valid 0..31)
//  seg         output  7  segments {g,f,e,d,c,b,a}, active-low
//  an          output  2  digit anodes {tens,ones}, active-low
//  wrap_pulse  output  1  one-cycle strobe per detected wrap
//  wrap_cnt    output  8  number of wraps since reset, saturates at 255
// BEHAVIOUR
//  Clocking: single clock. rst=0 asynchronously clears all state, regardless of current activity.
//  Reset values: seg=7'h7F, an=2'b11, wrap_pulse=0, wrap_cnt=0, val_q=0, digit_sel=0 (ones),
//    div_cnt=0, flash_cnt=0. val_q=0 matches the upstream counter's reset value.
//  Sampling: val_q <= value every clock. No valid handshake; value is always live.
//  Wrap detect: wrap_pulse <= (val_q==30 && value==0) || (val_q==0 && value==30).
//    Pulse is high in the same cycle in which val_q takes the new value.
//    Any other jump, including 31->0, holding at 0, or 30->29, is not a wrap.
//  wrap_cnt: increments on each wrap_pulse; holds at 8'hFF.
//  Flash: on wrap detect, flash_cnt <= FLASH_CYC. A retrigger reloads it.
//    Otherwise flash_cnt decrements to 0 and stops. While flash_cnt!=0, an=2'b11.
//  Scan: div_cnt counts 0..SCAN_DIV-1 and wraps. At the terminal count digit_sel toggles.
//    digit_sel=0 selects ones (an=2'b10); digit_sel=1 selects tens (an=2'b01).
//  Digit math, combinational from val_q:
//    tens = 3 if val_q>=30, 2 if >=20, 1 if >=10, else 0
//    ones = val_q - 10*tens (4-bit result; no wider arithmetic)
//  Leading-zero blank: tens==0 and digit_sel==1 -> an=2'b11, seg=7'h7F.
//  Decoder (active-low, gfedcba):
//    0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//  Output register: seg and an are registered from val_q, digit_sel and flash_cnt.
//    They reflect a new value two clock edges after it is presented on value.
//  Priority: flash blank > leading-zero blank > normal digit.
//    seg=7'h7F whenever an=2'b11.
//  Simultaneous events: a wrap coinciding with a digit toggle does both.
//    A wrap coinciding with the flash expiring reloads the flash.
// TESTING (bench uses SCAN_DIV=4, FLASH_CYC=8)
//  1. Hold rst=0 for mid-scan cycles -> seg=7F, an=11, wrap_cnt=0 immediately (async), and they
//     stay so while rst=0. After release, value=0 -> tens blanked, ones slot shows seg=40, an=10.
//  2. value=27 held -> every 4 clocks an alternates 10 (seg=78) / 01 (seg=24).
//     Check the 2-edge latency from the value change.
//  3. value 29,30,0 on consecutive clocks -> wrap_pulse high exactly 1 cycle, with val_q=0.
//     wrap_cnt=1; an=11 for 8 cycles, then the display shows "0".
//  4. value 1,0,30 (down-count wrap) -> wrap_pulse once.
//     Then 30->29 and 31->0 -> no pulse; wrap_cnt unchanged.
//  5. A second wrap 3 cycles into a flash -> flash reloaded (blank lasts 8 more cycles).
//     300 wraps total -> wrap_cnt saturates at FF.
//  6. value=9 -> tens blanked (an=11 during the tens slot), ones seg=10.
//     value=10 -> tens seg=79, ones seg=40.

Source files
------------

// File: rtl/count_display_driver.sv
// count_display_driver: 2-digit multiplexed 7-segment driver for a 0..30 wrapping counter
//
// Samples the upstream counter value every clock, splits it into tens/ones,
// and scans the two digits of a common-anode display. Counter wrap events
// (30->0 up, 0->30 down) are strobed, counted (saturating) and blank the
// display for FLASH_CYC clocks.
//
// Parameters:
//   SCAN_DIV   clocks per digit slot (>=2)
//   FLASH_CYC  clocks the display stays blanked after a wrap (>=1)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   value[4:0]  in   live counter value from upstream
//   seg[6:0]    out  segments {g,f,e,d,c,b,a}, active low, registered
//   an[1:0]     out  digit anodes {tens,ones}, active low, registered
//   wrap_pulse  out  one-cycle strobe per detected wrap
//   wrap_cnt    out  wraps since reset, saturating at 255
module count_display_driver #(
    parameter int SCAN_DIV  = 1000,
    parameter int FLASH_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] value,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap_pulse,
    output logic [7:0] wrap_cnt
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(FLASH_CYC + 1);

    logic [4:0]    val_q;
    logic [DW-1:0] div_cnt;
    logic [FW-1:0] flash_cnt;
    logic          digit_sel;
    logic          wrap_det;
    logic          div_end;
    logic [1:0]    tens;
    logic [3:0]    ones;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_d;
    logic [1:0]    an_d;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h40;
            4'd1:    dec7 = 7'h79;
            4'd2:    dec7 = 7'h24;
            4'd3:    dec7 = 7'h30;
            4'd4:    dec7 = 7'h19;
            4'd5:    dec7 = 7'h12;
            4'd6:    dec7 = 7'h02;
            4'd7:    dec7 = 7'h78;
            4'd8:    dec7 = 7'h00;
            4'd9:    dec7 = 7'h10;
            default: dec7 = 7'h7F;
        endcase
    endfunction

    // Only the true modular wraps count; 31->0 and other jumps are ignored.
    assign wrap_det = (val_q == 5'd30 && value == 5'd0) || (val_q == 5'd0 && value == 5'd30);
    assign div_end  = div_cnt == DW'(SCAN_DIV - 1);

    always_comb begin
        tens  = (val_q >= 5'd30) ? 2'd3 : (val_q >= 5'd20) ? 2'd2 : (val_q >= 5'd10) ? 2'd1 : 2'd0;
        ones  = 4'(val_q - 5'(tens) * 5'd10);
        digit = digit_sel ? {2'b00, tens} : ones;
        blank = (flash_cnt != '0) || (digit_sel && tens == 2'd0);
        an_d  = blank ? 2'b11 : (digit_sel ? 2'b01 : 2'b10);
        seg_d = blank ? 7'h7F : dec7(digit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q      <= '0;
            div_cnt    <= '0;
            digit_sel  <= 1'b0;
            flash_cnt  <= '0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            seg        <= 7'h7F;
            an         <= 2'b11;
        end else begin
            val_q      <= value;
            div_cnt    <= div_end ? '0 : div_cnt + 1'b1;
            digit_sel  <= digit_sel ^ div_end;
            // A wrap always reloads, even on the cycle the flash would expire.
            flash_cnt  <= wrap_det ? FW'(FLASH_CYC) : (flash_cnt != '0) ? flash_cnt - 1'b1 : flash_cnt;
            wrap_pulse <= wrap_det;
            wrap_cnt   <= (wrap_det && wrap_cnt != 8'hFF) ? wrap_cnt + 1'b1 : wrap_cnt;
            seg        <= seg_d;
            an         <= an_d;
        end
    end

endmodule

// File: tb/tb_count_display_driver.sv
// tb_count_display_driver: checks the display driver against a formula-based model
module tb_count_display_driver;

    localparam int SD = 4;
    localparam int FC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] value = '0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;

    count_display_driver #(.SCAN_DIV(SD), .FLASH_CYC(FC)) dut (
        .clk(clk), .rst(rst), .value(value), .seg(seg), .an(an),
        .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [6:0] dec_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model: k = clock edges since reset release, last_w = edge of latest wrap.
    int k;
    int last_w;
    int m_wraps;
    int m_vq;
    int shown_dsel;

    typedef struct {
        logic [4:0] v;
        logic [6:0] ones_seg;
        logic [6:0] tens_seg;
        logic [1:0] tens_an;
    } row_t;
    row_t tab [12];

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int flash_at(input int n);
        if (last_w < 0 || n - last_w >= FC) return 0;
        return FC - (n - last_w);
    endfunction

    task automatic model_reset();
        k = 0;
        last_w = -1;
        m_wraps = 0;
        m_vq = 0;
    endtask

    task automatic step(input logic [4:0] v);
        int tens_d;
        int e_seg;
        int e_an;
        bit w;
        value = v;
        @(posedge clk);
        #1;
        shown_dsel = (k / SD) % 2;
        tens_d = m_vq / 10;
        if (flash_at(k) != 0 || (shown_dsel == 1 && tens_d == 0)) begin
            e_seg = 'h7F;
            e_an = 3;
        end else begin
            e_an = shown_dsel ? 1 : 2;
            e_seg = dec_tab[shown_dsel ? tens_d : m_vq % 10];
        end
        w = (m_vq == 30 && v == 0) || (m_vq == 0 && v == 30);
        if (w) begin
            last_w = k + 1;
            if (m_wraps < 255) m_wraps++;
        end
        m_vq = int'(v);
        k++;
        chk("seg", int'(seg), e_seg);
        chk("an", int'(an), e_an);
        chk("wrap_pulse", int'(wrap_pulse), int'(w));
        chk("wrap_cnt", int'(wrap_cnt), m_wraps);
    endtask

    logic [4:0] pick [4] = '{5'd0, 5'd30, 5'd29, 5'd31};

    initial begin
        int cnt;
        int wc0;
        tab[0]  = '{5'd0,  7'h40, 7'h7F, 2'b11};
        tab[1]  = '{5'd27, 7'h78, 7'h24, 2'b01};
        tab[2]  = '{5'd9,  7'h10, 7'h7F, 2'b11};
        tab[3]  = '{5'd10, 7'h40, 7'h79, 2'b01};
        tab[4]  = '{5'd30, 7'h40, 7'h30, 2'b01};
        tab[5]  = '{5'd31, 7'h79, 7'h30, 2'b01};
        tab[6]  = '{5'd15, 7'h12, 7'h79, 2'b01};
        tab[7]  = '{5'd26, 7'h02, 7'h24, 2'b01};
        tab[8]  = '{5'd18, 7'h00, 7'h79, 2'b01};
        tab[9]  = '{5'd23, 7'h30, 7'h24, 2'b01};
        tab[10] = '{5'd14, 7'h19, 7'h79, 2'b01};
        tab[11] = '{5'd21, 7'h79, 7'h24, 2'b01};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg", int'(seg), 'h7F);
        chk("rst_an", int'(an), 3);
        chk("rst_wcnt", int'(wrap_cnt), 0);
        #2 rst = 1'b1;
        model_reset();

        step(5'd0);
        chk("first_ones_seg", int'(seg), 'h40);
        chk("first_ones_an", int'(an), 2);

        // Digit decode and blanking per held value, checked in both scan slots.
        for (int r = 0; r < 12; r++) begin
            repeat (20) step(tab[r].v);
            for (int i = 0; i < 2 * SD; i++) begin
                step(tab[r].v);
                if (shown_dsel == 0) begin
                    chk("tab_ones_seg", int'(seg), int'(tab[r].ones_seg));
                    chk("tab_ones_an", int'(an), 2);
                end else begin
                    chk("tab_tens_seg", int'(seg), int'(tab[r].tens_seg));
                    chk("tab_tens_an", int'(an), int'(tab[r].tens_an));
                end
            end
        end

        // Up-count wrap: single pulse, 8-cycle blank, then "0".
        repeat (12) step(5'd28);
        wc0 = int'(wrap_cnt);
        step(5'd29);
        step(5'd30);
        chk("pre_wrap_pulse", int'(wrap_pulse), 0);
        step(5'd0);
        chk("up_wrap_pulse", int'(wrap_pulse), 1);
        chk("up_wrap_cnt", int'(wrap_cnt), wc0 + 1);
        cnt = 0;
        for (int i = 0; i < FC; i++) begin
            step(5'd0);
            if (an == 2'b11 && seg == 7'h7F) cnt++;
            if (i == 0) chk("pulse_one_cycle", int'(wrap_pulse), 0);
        end
        chk("flash_len", cnt, FC);
        cnt = 0;
        for (int i = 0; i < 2 * SD; i++) begin
            step(5'd0);
            if (an == 2'b10 && seg == 7'h40) cnt++;
        end
        chk("post_flash_zero", cnt, SD);

        // Down-count wrap, then non-wrap jumps.
        repeat (3) step(5'd1);
        step(5'd0);
        step(5'd30);
        chk("down_wrap_pulse", int'(wrap_pulse), 1);
        wc0 = int'(wrap_cnt);
        cnt = 0;
        step(5'd30); cnt += int'(wrap_pulse);
        step(5'd29); cnt += int'(wrap_pulse);
        step(5'd31); cnt += int'(wrap_pulse);
        step(5'd0);  cnt += int'(wrap_pulse);
        step(5'd0);  cnt += int'(wrap_pulse);
        chk("nonwrap_pulses", cnt, 0);
        chk("nonwrap_cnt", int'(wrap_cnt), wc0);

        // Retrigger 3 cycles into a flash: blank spans 3 + FC cycles.
        repeat (12) step(5'd29);
        step(5'd30);
        step(5'd0);
        cnt = 0;
        step(5'd0);  cnt += int'(an == 2'b11);
        step(5'd0);  cnt += int'(an == 2'b11);
        step(5'd30); cnt += int'(an == 2'b11);
        chk("retrig_pulse", int'(wrap_pulse), 1);
        for (int i = 0; i < 12; i++) begin
            step(5'd30);
            cnt += int'(an == 2'b11);
        end
        chk("retrig_blank_len", cnt, 3 + FC);

        // Saturation: every edge is a wrap.
        for (int i = 0; i < 300; i++) step((i % 2) ? 5'd30 : 5'd0);
        chk("wrap_cnt_sat", int'(wrap_cnt), 255);

        // Random stimulus, biased toward wrap-relevant values.
        rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 1) ? 5'($urandom_range(0, 31)) : pick[$urandom_range(0, 3)]);

        // Asynchronous reset mid-scan, held across several edges.
        #2 rst = 1'b0;
        value = 5'd17;
        #1;
        chk("async_rst_seg", int'(seg), 'h7F);
        chk("async_rst_an", int'(an), 3);
        chk("async_rst_wcnt", int'(wrap_cnt), 0);
        chk("async_rst_pulse", int'(wrap_pulse), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_rst_seg", int'(seg), 'h7F);
            chk("hold_rst_an", int'(an), 3);
            chk("hold_rst_wcnt", int'(wrap_cnt), 0);
        end
        #2 rst = 1'b1;
        model_reset();
        step(5'd0);
        chk("rerst_ones_seg", int'(seg), 'h40);
        chk("rerst_ones_an", int'(an), 2);
        repeat (2 * SD) step(5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
